// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped, write-back, write-allocate data cache.
//
// It answers the pipeline's D-cache requests and fills from, or writes back to,
// a slow memory that moves one 128-bit block at a time.
// Hits complete in the same cycle. A miss raises proc_stall while two things
// happen in order: a dirty victim is written back, then the new block is fetched.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   proc_read     load request (held stable while stalled)
//   proc_write    store request (held stable while stalled)
//   proc_addr     word address: {tag, index, word offset[1:0]}
//   proc_wdata    store data
//   proc_stall    request not yet complete
//   proc_rdata    load data; valid when proc_read && !proc_stall, else 0
//   mem_read      block fetch request (registered)
//   mem_write     block write-back request (registered)
//   mem_addr      block address {tag, index} (registered)
//   mem_wdata     victim block; word 0 in [31:0] (registered)
//   mem_rdata     fetched block, same word order
//   mem_ready     one-cycle pulse: memory finished the current request
module dcache_dm_wb #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       proc_read,
  input  logic                       proc_write,
  input  logic [29:0]                proc_addr,
  input  logic [31:0]                proc_wdata,
  output logic                       proc_stall,
  output logic [31:0]                proc_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [TAG_W+INDEX_W-1:0]   mem_addr,
  output logic [127:0]               mem_wdata,
  input  logic [127:0]               mem_rdata,
  input  logic                       mem_ready
);

  localparam int NUM_LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [TAG_W-1:0]   proc_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic [6:0]         word_lsb;
  logic               req;
  logic               hit;

  assign proc_tag = proc_addr[29 -: TAG_W];
  assign idx      = proc_addr[2 +: INDEX_W];
  assign off      = proc_addr[1:0];
  assign word_lsb = {off, 5'b0_0000};
  assign req      = proc_read | proc_write;
  assign hit      = valid_q[idx] && (tag_q[idx] == proc_tag);

  // A request is complete only in IDLE, and only once it hits. The access that
  // caused a miss hits on the cycle the FSM returns to IDLE.
  assign proc_stall = (state != IDLE) || (req && !hit);
  assign proc_rdata = (proc_read && hit) ? data_q[idx][word_lsb +: 32] : 32'h0;

  // Control: FSM, line status bits and the registered memory interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[idx], idx};
              mem_wdata <= data_q[idx];
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {proc_tag, idx};
            end
          end else if (proc_write && hit) begin
            // A read+write request is treated as a store.
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state     <= ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {proc_tag, idx};
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state        <= IDLE;
            mem_read     <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset. The valid bits guard them, and while
  // rst is high the FSM sits in IDLE with every line invalid, so neither
  // branch can fire.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_ready) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= proc_tag;
    end else if (state == IDLE && proc_write && hit) begin
      data_q[idx][word_lsb +: 32] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
module tb_dcache_dm_wb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK1 = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
  localparam logic [127:0] BLK2 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] BLK3 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] BLK4 = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] BLK5 = 128'h99999999_88888888_AAAA0002_AAAA0001;

  dcache_dm_wb dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are changed there.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  initial begin
    // Reset state
    next();
    next();
    #1;
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_rdata", proc_rdata, 32'h0);
    next();
    rst = 1'b0;

    // 1. Cold read of 0x10, memory answers on the third ALLOCATE cycle
    next();
    req(1, 0, 30'h10, 32'h0);
    #1;
    check("t1_miss_stall", proc_stall, 1'b1);
    check("t1_no_mem_yet", mem_read, 1'b0);
    next();
    #1;
    check("t1_alloc_read", mem_read, 1'b1);
    check("t1_alloc_nowrite", mem_write, 1'b0);
    check("t1_alloc_addr", mem_addr, 28'h4);
    check("t1_alloc_stall", proc_stall, 1'b1);
    next();
    #1;
    check("t1_wait_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b1;
    mem_rdata = BLK1;
    #1;
    check("t1_ready_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b0;
    #1;
    check("t1_done_stall", proc_stall, 1'b0);
    check("t1_done_rdata", proc_rdata, 32'hBBBBAAAA);
    check("t1_done_mem_read", mem_read, 1'b0);

    // 2. Read hit, same cycle
    proc_addr = 30'h13;
    #1;
    check("t2_hit_stall", proc_stall, 1'b0);
    check("t2_hit_rdata", proc_rdata, 32'h44443333);
    next();
    #1;
    check("t2_no_mem_read", mem_read, 1'b0);
    check("t2_no_mem_write", mem_write, 1'b0);

    // 3. Write hit, then dirty eviction by a different tag on index 4
    req(0, 1, 30'h11, 32'hCAFEF00D);
    #1;
    check("t3_whit_stall", proc_stall, 1'b0);
    check("t3_whit_rdata0", proc_rdata, 32'h0);
    next();
    req(1, 0, 30'h11, 32'h0);
    #1;
    check("t3_readback", proc_rdata, 32'hCAFEF00D);
    proc_addr = 30'h111;
    #1;
    check("t3_evict_stall", proc_stall, 1'b1);
    next();
    #1;
    check("t3_wb_write", mem_write, 1'b1);
    check("t3_wb_noread", mem_read, 1'b0);
    check("t3_wb_addr", mem_addr, 28'h4);
    check("t3_wb_word1", mem_wdata[63:32], 32'hCAFEF00D);
    check("t3_wb_data", mem_wdata, 128'h44443333_22221111_CAFEF00D_BBBBAAAA);
    next();
    #1;
    check("t3_wb_hold_write", mem_write, 1'b1);
    check("t3_wb_hold_addr", mem_addr, 28'h4);
    next();
    mem_ready = 1'b1;
    #1;
    check("t3_wb_ready_stall", proc_stall, 1'b1);
    next();
    mem_rdata = BLK2;
    #1;
    check("t3_al_write_drop", mem_write, 1'b0);
    check("t3_al_read", mem_read, 1'b1);
    check("t3_al_addr", mem_addr, 28'h44);
    check("t3_al_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b0;
    #1;
    check("t3_done_stall", proc_stall, 1'b0);
    check("t3_done_rdata", proc_rdata, 32'h0000000B);
    check("t3_done_mem_read", mem_read, 1'b0);

    // 4. Write miss on invalid index 0 (tag 1, offset 2): allocate only
    next();
    req(0, 1, 30'h22, 32'h12345678);
    #1;
    check("t4_miss_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b1;
    mem_rdata = BLK3;
    #1;
    check("t4_al_read", mem_read, 1'b1);
    check("t4_al_nowrite", mem_write, 1'b0);
    check("t4_al_addr", mem_addr, 28'h8);
    next();
    mem_ready = 1'b0;
    #1;
    check("t4_merge_stall", proc_stall, 1'b0);
    next();
    req(1, 0, 30'h20, 32'h0);
    #1;
    check("t4_word0", proc_rdata, 32'h00000000);
    proc_addr = 30'h21;
    #1;
    check("t4_word1", proc_rdata, 32'h11111111);
    proc_addr = 30'h22;
    #1;
    check("t4_word2", proc_rdata, 32'h12345678);
    proc_addr = 30'h23;
    #1;
    check("t4_word3", proc_rdata, 32'h33333333);
    // The line must be dirty: a conflicting read writes it back.
    proc_addr = 30'h40;
    #1;
    check("t4_evict_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b1;
    #1;
    check("t4_wb_write", mem_write, 1'b1);
    check("t4_wb_addr", mem_addr, 28'h8);
    check("t4_wb_data", mem_wdata, 128'h33333333_12345678_11111111_00000000);
    next();
    mem_rdata = BLK4;
    #1;
    check("t4_al_addr2", mem_addr, 28'h10);
    check("t4_al_read2", mem_read, 1'b1);
    next();
    mem_ready = 1'b0;
    #1;
    check("t4_done_rdata", proc_rdata, 32'h44444444);

    // 6. mem_ready with no request is ignored; read+write counts as a store
    next();
    req(0, 0, 30'h0, 32'h0);
    mem_ready = 1'b1;
    #1;
    check("t6_idle_stall", proc_stall, 1'b0);
    next();
    mem_ready = 1'b0;
    #1;
    check("t6_idle_no_read", mem_read, 1'b0);
    check("t6_idle_no_write", mem_write, 1'b0);
    req(1, 0, 30'h113, 32'h0);
    #1;
    check("t6_still_hit", proc_stall, 1'b0);
    check("t6_still_rdata", proc_rdata, 32'h0000000D);
    next();
    req(1, 1, 30'h112, 32'hA5A5A5A5);
    #1;
    check("t6_rw_stall", proc_stall, 1'b0);
    next();
    req(1, 0, 30'h112, 32'h0);
    #1;
    check("t6_rw_written", proc_rdata, 32'hA5A5A5A5);
    proc_addr = 30'h12;
    #1;
    check("t6_evict_stall", proc_stall, 1'b1);
    next();
    mem_ready = 1'b1;
    #1;
    check("t6_wb_write", mem_write, 1'b1);
    check("t6_wb_addr", mem_addr, 28'h44);
    check("t6_wb_data", mem_wdata, 128'h0000000D_A5A5A5A5_0000000B_0000000A);
    next();
    mem_rdata = BLK1;
    #1;
    check("t6_al_addr", mem_addr, 28'h4);
    next();
    mem_ready = 1'b0;
    #1;
    check("t6_done_rdata", proc_rdata, 32'h22221111);

    // 5. Reset in the middle of an ALLOCATE
    next();
    req(1, 0, 30'h08, 32'h0);
    #1;
    check("t5_miss_stall", proc_stall, 1'b1);
    next();
    #1;
    check("t5_al_read", mem_read, 1'b1);
    check("t5_al_addr", mem_addr, 28'h2);
    rst = 1'b1;
    #1;
    check("t5_rst_read_drop", mem_read, 1'b0);
    check("t5_rst_addr", mem_addr, 28'h0);
    proc_addr = 30'h10;
    #1;
    check("t5_rst_invalidated", proc_stall, 1'b1);
    next();
    rst = 1'b0;
    proc_addr = 30'h08;
    #1;
    check("t5_miss_again", proc_stall, 1'b1);
    next();
    mem_ready = 1'b1;
    mem_rdata = BLK5;
    #1;
    check("t5_refetch_read", mem_read, 1'b1);
    check("t5_refetch_addr", mem_addr, 28'h2);
    next();
    mem_ready = 1'b0;
    #1;
    check("t5_done_stall", proc_stall, 1'b0);
    check("t5_done_rdata", proc_rdata, 32'hAAAA0001);
    next();
    req(0, 0, 30'h0, 32'h0);
    #1;
    check("t5_final_rdata0", proc_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
